// File: rtl/quad_sum_scheduler_if.sv
// Bus bundle for quad_sum_scheduler: requester handshake, adder port and result stream.
interface quad_sum_scheduler_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*96-1:0] req_ops;
  logic [NREQ-1:0]    req_ready;
  logic [95:0]        add_ops;
  logic               add_vld;
  logic [51:0]        add_sum;
  logic               res_valid;
  logic               res_ready;
  logic [ID_W-1:0]    res_id;
  logic [51:0]        res_sum;

  modport slave (
    input  req_valid, req_ops, add_sum, res_ready,
    output req_ready, add_ops, add_vld, res_valid, res_id, res_sum
  );

  modport master (
    output req_valid, req_ops, add_sum, res_ready,
    input  req_ready, add_ops, add_vld, res_valid, res_id, res_sum
  );
endinterface

// File: rtl/quad_sum_scheduler.sv
// Round-robin sharing of one external quad 12-bit adder among NREQ requesters,
// with credit-based issue into a tagged first-word fall-through result FIFO.
module quad_sum_scheduler #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ID_W        = 2,
  parameter int unsigned ADD_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  quad_sum_scheduler_if.slave  bus
);

  localparam int unsigned NSTG = ADD_LATENCY + 1;
  localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned EW   = ID_W + 52;

  // Reset asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  logic [ID_W-1:0] ptr_q;
  logic [95:0]     add_ops_q;
  logic            add_vld_q;
  logic            tag_vld_q [NSTG];
  logic [ID_W-1:0] tag_id_q  [NSTG];
  logic [EW-1:0]   mem       [FIFO_DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   occ_q;

  logic            grant_any, credit, hs, push, pop, res_valid;
  logic [ID_W-1:0] grant_idx;
  int unsigned     inflight;
  logic [EW-1:0]   head;

  always_comb begin
    grant_idx = '0;
    grant_any = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!grant_any && bus.req_valid[(32'(ptr_q) + k) % NREQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((32'(ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    inflight = 0;
    for (int unsigned s = 0; s < NSTG; s++) inflight = inflight + {31'b0, tag_vld_q[s]};
  end

  // Credits cover FIFO entries plus results still travelling through the adder.
  assign credit = rst_int_n && ((32'(occ_q) + inflight) < FIFO_DEPTH);
  assign hs     = credit && grant_any;

  always_comb begin
    bus.req_ready = '0;
    if (hs) bus.req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      ptr_q     <= ID_W'(NREQ - 1);
      add_ops_q <= '0;
      add_vld_q <= 1'b0;
    end else begin
      add_vld_q <= hs;
      if (hs) begin
        ptr_q     <= grant_idx;
        add_ops_q <= bus.req_ops[32'(grant_idx) * 96 +: 96];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      for (int unsigned s = 0; s < NSTG; s++) begin
        tag_vld_q[s] <= 1'b0;
        tag_id_q[s]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= hs;
      tag_id_q[0]  <= grant_idx;
      for (int unsigned s = 1; s < NSTG; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (32'(p) == FIFO_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  assign push      = tag_vld_q[NSTG-1];
  assign res_valid = (occ_q != '0);
  assign pop       = res_valid && bus.res_ready;

  always_ff @(posedge clk) begin
    if (push) mem[wr_q] <= {tag_id_q[NSTG-1], bus.add_sum};
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      if (push) wr_q <= ptr_inc(wr_q);
      if (pop)  rd_q <= ptr_inc(rd_q);
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign head          = mem[rd_q];
  assign bus.res_valid = res_valid;
  assign bus.res_id    = res_valid ? head[EW-1:52] : '0;
  assign bus.res_sum   = res_valid ? head[51:0] : '0;
  assign bus.add_ops   = add_ops_q;
  assign bus.add_vld   = add_vld_q;

endmodule

// File: tb/tb_quad_sum_scheduler.sv
// Self-checking bench for quad_sum_scheduler: adder model, round-robin model and
// result scoreboard, plus directed latency, back-pressure and reset scenarios.
module tb_quad_sum_scheduler;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned ID_W  = 2;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [51:0]     sum;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quad_sum_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  quad_sum_scheduler #(
    .NREQ(NREQ), .ID_W(ID_W), .ADD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [51:0] quad_add(input logic [95:0] o);
    logic [51:0] r;
    for (int i = 0; i < 4; i++) r[13*i +: 13] = {1'b0, o[24*i +: 12]} + {1'b0, o[24*i+12 +: 12]};
    return r;
  endfunction

  // Two-register adder model: result lines up LAT cycles after add_ops.
  logic [51:0] s1, s2;
  always @(posedge clk) begin
    s1 <= quad_add(bus.add_ops);
    s2 <= s1;
  end
  assign bus.add_sum = s2;

  int   n_cmp = 0, n_err = 0, cyc = 0, ptr_m = NREQ - 1, n_hs = 0;
  exp_t sb[$];
  int   gl_idx[$], gl_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon
    int   e_idx;
    exp_t e;
    if (rst_n) begin
      if (bus.req_ready != '0) begin
        e_idx = -1;
        for (int k = 1; k <= NREQ; k++)
          if (e_idx < 0 && bus.req_valid[(ptr_m + k) % NREQ]) e_idx = (ptr_m + k) % NREQ;
        check("ready_subset_valid", 64'(bus.req_ready & ~bus.req_valid), 0);
        if (e_idx >= 0) begin
          check("grant", 64'(bus.req_ready), 64'(1) << e_idx);
          sb.push_back({ID_W'(e_idx), quad_add(bus.req_ops[96*e_idx +: 96])});
          gl_idx.push_back(e_idx);
          gl_cyc.push_back(cyc);
          ptr_m = e_idx;
          n_hs++;
        end
      end
      if (bus.res_valid && bus.res_ready) begin
        if (sb.size() == 0) check("pop_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("res_id", 64'(bus.res_id), 64'(e.id));
          check("res_sum", 64'(bus.res_sum), 64'(e.sum));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    sb.delete();
    ptr_m = NREQ - 1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic drain(input string tag);
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.res_valid) break;
    end
    check(tag, 64'(sb.size()), 0);
    tick();
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NREQ; i++)
      for (int j = 0; j < 8; j++) bus.req_ops[96*i + 12*j +: 12] = 12'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int t_hs, t_res, p, cnt;
    bus.req_valid = '1;
    bus.req_ops   = '0;
    bus.res_ready = 1'b1;
    tick();
    check("rst_req_ready", 64'(bus.req_ready), 0);
    check("rst_add_ops", 64'(bus.add_ops), 0);
    check("rst_add_vld", 64'(bus.add_vld), 0);
    check("rst_res_valid", 64'(bus.res_valid), 0);
    check("rst_res_id", 64'(bus.res_id), 0);
    check("rst_res_sum", 64'(bus.res_sum), 0);
    bus.req_valid = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Single request latency and packing.
    bus.req_ops[192 +: 96] = {12'd0, 12'd0, 12'd0, 12'd0, 12'd4, 12'd3, 12'd2, 12'd1};
    bus.req_valid = 4'b0100;
    t_hs = -100;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready[2]) begin t_hs = cyc; break; end
    end
    tick();
    bus.req_valid = '0;
    t_res = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.res_valid) begin t_res = cyc; break; end
    end
    check("t1_latency", 64'(t_res - t_hs), 4);
    check("t1_id", 64'(bus.res_id), 2);
    check("t1_apb", 64'(bus.res_sum[12:0]), 3);
    check("t1_cpd", 64'(bus.res_sum[25:13]), 7);
    drain("t1_drain");

    // Round robin from reset with all requesters valid.
    do_reset();
    rand_ops();
    gl_idx.delete();
    gl_cyc.delete();
    bus.req_valid = '1;
    repeat (12) tick();
    bus.req_valid = '0;
    if (gl_idx.size() < 5) check("t2_grant_count", 64'(gl_idx.size()), 5);
    else begin
      for (int k = 0; k < 5; k++) check("t2_grant_order", 64'(gl_idx[k]), 64'(k % NREQ));
      for (int k = 1; k < 4; k++) check("t2_back_to_back", 64'(gl_cyc[k] - gl_cyc[0]), 64'(k));
    end
    drain("t2_drain");

    // Back-pressure fills credits, release resumes issue one cycle after first pop.
    rand_ops();
    bus.res_ready = 1'b0;
    n_hs = 0;
    bus.req_valid = '1;
    repeat (20) tick();
    check("t3_hs_count", 64'(n_hs), 4);
    @(negedge clk);
    check("t3_stalled", 64'(bus.req_ready), 0);
    check("t3_full", 64'(bus.res_valid), 1);
    tick();
    gl_cyc.delete();
    bus.res_ready = 1'b1;
    p = cyc;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t3_pop_stream", 64'(bus.res_valid), 1);
    end
    if (gl_cyc.size() == 0) check("t3_resume_seen", 0, 1);
    else check("t3_resume", 64'(gl_cyc[0] - p), 1);
    drain("t3_drain");

    // Carry out of every lane reaches the result.
    rand_ops();
    bus.req_ops[96 +: 24] = {12'hFFF, 12'hFFF};
    bus.req_ops[96+72 +: 24] = {12'h800, 12'h800};
    bus.req_valid = 4'b0010;
    n_hs = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (n_hs != 0) break;
    end
    tick();
    bus.req_valid = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.res_valid) break;
    end
    check("t4_apb", 64'(bus.res_sum[12:0]), 64'h1FFE);
    check("t4_gph", 64'(bus.res_sum[51:39]), 64'h1000);
    drain("t4_drain");

    // Reset with two transactions in flight.
    n_hs = 0;
    bus.req_valid = 4'b0001;
    repeat (2) tick();
    check("t5_inflight", 64'(n_hs), 2);
    rst_n = 1'b0;
    sb.delete();
    ptr_m = NREQ - 1;
    #1;
    check("t5_req_ready", 64'(bus.req_ready), 0);
    check("t5_add_vld", 64'(bus.add_vld), 0);
    check("t5_add_ops", 64'(bus.add_ops), 0);
    check("t5_res_valid", 64'(bus.res_valid), 0);
    check("t5_res_sum", 64'(bus.res_sum), 0);
    repeat (2) tick();
    bus.req_valid = '0;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.res_valid) cnt++;
    end
    check("t5_no_results", 64'(cnt), 0);
    tick();

    // Random traffic, first biased toward a full FIFO with concurrent push/pop.
    for (int i = 0; i < 300; i++) begin
      rand_ops();
      bus.req_valid = NREQ'($urandom);
      bus.res_ready = (i < 120) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
